// File: rtl/apb4_pkg.sv
// Shared types and address decode for the APB4 register-array completer.
package apb4_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  // Geometry of the default 32-bit bus; instances with other widths derive
  // their own copies from DATA_WIDTH.
  localparam int BUS_DATA_WIDTH = 32;
  localparam int STRB_WIDTH     = BUS_DATA_WIDTH / 8;
  localparam int WORD_LSB       = $clog2(STRB_WIDTH);

  // Word index of a byte address.
  function automatic logic [31:0] word_index(input logic [31:0] addr,
                                             input int unsigned lsb);
    return addr >> lsb;
  endfunction

  // Out of range, misaligned, or (when enabled) a non-secure access to the
  // secure upper half of the word range.
  function automatic logic decode_err(input logic [31:0] addr,
                                      input int unsigned lsb,
                                      input int unsigned depth,
                                      input logic [2:0]  prot,
                                      input logic        prot_en);
    logic [31:0] idx;
    logic [31:0] low_mask;
    idx      = addr >> lsb;
    low_mask = (32'd1 << lsb) - 32'd1;
    return (idx >= depth) || ((addr & low_mask) != 32'd0) ||
           (prot_en && prot[1] && (idx >= depth / 2));
  endfunction

endpackage

// File: rtl/apb4_slave_mem_if.sv
// APB4 bus bundle; signal names match the existing APB agent's pins.
interface apb4_slave_mem_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) ();
  logic                    psel_i;
  logic                    penable_i;
  logic                    pwrite_i;
  logic [ADDR_WIDTH-1:0]   paddr_i;
  logic [DATA_WIDTH-1:0]   pwdata_i;
  logic [DATA_WIDTH/8-1:0] pstrb_i;
  logic [2:0]              pprot_i;
  logic [DATA_WIDTH-1:0]   prdata_o;
  logic                    pready_o;
  logic                    pslverr_o;

  modport master (
    output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i, pprot_i,
    input  prdata_o, pready_o, pslverr_o
  );

  modport slave (
    input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i, pprot_i,
    output prdata_o, pready_o, pslverr_o
  );
endinterface

// File: rtl/apb4_byte_mem.sv
// DEPTH x DATA_WIDTH word array split into byte lanes: async clear,
// per-byte write enables, asynchronous read port.
module apb4_byte_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int IDX_W      = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [IDX_W-1:0]        waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [IDX_W-1:0]        raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;

  for (genvar b = 0; b < NUM_BYTES; b++) begin : g_lane
    logic [7:0] lane [DEPTH];

    // One byte lane: cleared on reset, written only when its strobe is set.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) lane[i] <= '0;
      end else if (we && wstrb[b]) begin
        lane[waddr] <= wdata[b*8 +: 8];
      end
    end

    assign rdata[b*8 +: 8] = lane[raddr];
  end

endmodule

// File: rtl/apb4_slave_mem.sv
// APB4 completer: word-addressed memory with byte strobes, WAIT_STATES
// wait cycles, range/alignment error response.
// Optional: define APB_PROT_CHECK_EN to make the upper half of the word
// range secure-only (pprot_i[1]=1 there -> error, no write, zero data).
module apb4_slave_mem
  import apb4_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic             pclk_i,
  input  logic             presetn_i,
  apb4_slave_mem_if.slave  bus
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef APB_PROT_CHECK_EN
  localparam logic PROT_EN = 1'b1;
`else
  localparam logic PROT_EN = 1'b0;
`endif

  state_t                state;
  state_t                phase;
  logic [3:0]            wait_cnt;
  logic                  write_q;
  logic                  err_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     strb_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [ADDR_WIDTH-1:0] paddr;
  logic [31:0]           addr_ext;
  logic                  setup_err;
  logic [IDX_W-1:0]      setup_idx;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  pready;
  logic                  complete;
  logic                  commit;

  assign paddr     = bus.paddr_i;
  assign addr_ext  = 32'(paddr);
  assign setup_err = decode_err(addr_ext, LSB, DEPTH, bus.pprot_i, PROT_EN);
  assign setup_idx = IDX_W'(word_index(addr_ext, LSB));

  // The SETUP phase is exactly the bus cycle showing psel & !penable while
  // idle; decoding it from the bus instead of registering it keeps the
  // zero-wait transfer at two cycles.
  assign phase = (state == IDLE && bus.psel_i && !bus.penable_i) ? SETUP : state;

  assign pready   = (state == ACCESS) && (wait_cnt == 4'd0);
  assign complete = (state == ACCESS) && bus.psel_i && bus.penable_i && pready;
  assign commit   = complete && write_q && !err_q;

  apb4_byte_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_mem (
    .clk   (pclk_i),
    .rst_n (presetn_i),
    .we    (commit),
    .wstrb (strb_q),
    .waddr (idx_q),
    .wdata (wdata_q),
    .raddr (setup_idx),
    .rdata (mem_rdata)
  );

  // Transfer FSM: capture the request in SETUP, count wait states in ACCESS.
  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      state    <= IDLE;
      wait_cnt <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      strb_q   <= '0;
      rdata_q  <= '0;
    end else begin
      case (phase)
        SETUP: begin
          state    <= ACCESS;
          write_q  <= bus.pwrite_i;
          err_q    <= setup_err;
          idx_q    <= setup_idx;
          wdata_q  <= bus.pwdata_i;
          strb_q   <= bus.pstrb_i;
          wait_cnt <= 4'(WAIT_STATES);
          rdata_q  <= (!bus.pwrite_i && !setup_err) ? mem_rdata : '0;
        end
        ACCESS: begin
          if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
          // Completion needs penable high, so the next setup phase is
          // always picked up from IDLE on the following cycle.
          if (!bus.psel_i || complete) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pready_o  = pready;
  assign bus.pslverr_o = pready && err_q;
  assign bus.prdata_o  = (pready && !write_q && !err_q) ? rdata_q : '0;

endmodule

// File: tb/tb_apb4_slave_mem.sv
// Three instances (WAIT_STATES 0, 3, 2) driven by directed transfers; a
// spec-level model predicts the outputs checked every cycle.
module tb_apb4_slave_mem;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int N  = 3;
`ifdef APB_PROT_CHECK_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  function automatic int ws(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 3 : 2);
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic          psel[N], penable[N], pwrite[N];
  logic [AW-1:0] paddr[N];
  logic [DW-1:0] pwdata[N];
  logic [3:0]    pstrb[N];
  logic [2:0]    pprot[N];
  logic          act_rdy[N], act_err[N];
  logic [DW-1:0] act_rd[N];
  logic          exp_rdy[N], exp_err[N];
  logic [DW-1:0] exp_rd[N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    apb4_slave_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    assign bus.psel_i    = psel[g];
    assign bus.penable_i = penable[g];
    assign bus.pwrite_i  = pwrite[g];
    assign bus.paddr_i   = paddr[g];
    assign bus.pwdata_i  = pwdata[g];
    assign bus.pstrb_i   = pstrb[g];
    assign bus.pprot_i   = pprot[g];
    assign act_rdy[g]    = bus.pready_o;
    assign act_err[g]    = bus.pslverr_o;
    assign act_rd[g]     = bus.prdata_o;
    apb4_slave_mem #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(64), .WAIT_STATES(ws(g))
    ) dut (
      .pclk_i(clk), .presetn_i(rst_n), .bus(bus)
    );
  end

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;
  logic [31:0] mm [N][64];

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, a, e);
    end
  endtask

  // Cycle-by-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (cmp_en && rst_n === 1'b1) begin
      for (int d = 0; d < N; d++) begin
        chk($sformatf("d%0d pready", d), 32'(act_rdy[d]), 32'(exp_rdy[d]));
        chk($sformatf("d%0d pslverr", d), 32'(act_err[d]), 32'(exp_err[d]));
        chk($sformatf("d%0d prdata", d), act_rd[d], exp_rd[d]);
      end
    end
  end

  function automatic logic model_err(input logic [AW-1:0] a, input logic [2:0] pr);
    int idx;
    idx = int'(a) / 4;
    return (idx >= 64) || (a[1:0] != 2'b00) || (PROT && pr[1] && idx >= 32);
  endfunction

  task automatic set_idle(input int d);
    psel[d] = 1'b0; penable[d] = 1'b0;
    exp_rdy[d] = 1'b0; exp_err[d] = 1'b0; exp_rd[d] = '0;
  endtask

  task automatic clear_model();
    for (int d = 0; d < N; d++)
      for (int i = 0; i < 64; i++) mm[d][i] = '0;
  endtask

  // One transfer; abort>=0 drops psel on that access cycle.
  task automatic xfer(input int d, input bit wr, input logic [AW-1:0] a,
                      input logic [31:0] wd, input logic [3:0] st,
                      input logic [2:0] pr, input int abort,
                      output logic [31:0] rd, output logic er, output int lat);
    logic e; logic [31:0] erd, w; int k, idx; bit done, rdy;
    idx = int'(a) / 4;
    e   = model_err(a, pr);
    erd = '0;
    if (!wr && !e) erd = mm[d][idx];
    rd = '0; er = 1'b0; lat = 99;
    @(posedge clk); #1;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a;
    pwdata[d] = wd; pstrb[d] = st; pprot[d] = pr;
    exp_rdy[d] = 1'b0; exp_err[d] = 1'b0; exp_rd[d] = '0;
    @(posedge clk); #1;
    k = 0; done = 1'b0;
    while (!done) begin
      if (k == abort) begin
        set_idle(d);
        @(posedge clk); #1;
        return;
      end
      penable[d] = 1'b1;
      if (k > 0) begin
        paddr[d] = a ^ 10'h2A4; pwdata[d] = ~wd; pstrb[d] = ~st; pwrite[d] = !wr;
      end
      rdy = (k >= ws(d));
      exp_rdy[d] = rdy;
      exp_err[d] = rdy ? e : 1'b0;
      exp_rd[d]  = rdy ? erd : '0;
      @(negedge clk);
      if (act_rdy[d] && lat == 99) lat = k + 2;
      if (rdy) begin rd = act_rd[d]; er = act_err[d]; end
      @(posedge clk); #1;
      if (rdy) done = 1'b1;
      k++;
    end
    set_idle(d);
    if (wr && !e) begin
      w = mm[d][idx];
      for (int b = 0; b < 4; b++) if (st[b]) w[8*b +: 8] = wd[8*b +: 8];
      mm[d][idx] = w;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd; logic er; int lat;
    rst_n = 1'b0;
    for (int d = 0; d < N; d++) begin
      set_idle(d); pwrite[d] = 1'b0; paddr[d] = '0; pwdata[d] = '0;
      pstrb[d] = '0; pprot[d] = '0;
    end
    clear_model();
    #12;
    for (int d = 0; d < N; d++) begin
      chk($sformatf("reset d%0d pready", d), 32'(act_rdy[d]), 32'd0);
      chk($sformatf("reset d%0d pslverr", d), 32'(act_err[d]), 32'd0);
      chk($sformatf("reset d%0d prdata", d), act_rd[d], 32'd0);
    end
    @(negedge clk); rst_n = 1'b1; cmp_en = 1'b1;

    // Basic write/read, zero wait states.
    xfer(0, 1, 10'h010, 32'hDEADBEEF, 4'hF, 3'b000, -1, rd, er, lat);
    chk("ws0 write latency", 32'(lat), 32'd2);
    xfer(0, 0, 10'h010, 32'h0, 4'h0, 3'b000, -1, rd, er, lat);
    chk("ws0 read latency", 32'(lat), 32'd2);
    chk("ws0 read data", rd, 32'hDEADBEEF);
    chk("ws0 read err", 32'(er), 32'd0);

    // Partial strobes.
    xfer(0, 1, 10'h010, 32'h11223344, 4'h5, 3'b000, -1, rd, er, lat);
    xfer(0, 0, 10'h010, 32'h0, 4'hF, 3'b000, -1, rd, er, lat);
    chk("strobe merge", rd, 32'hDE22BE44);

    // Three wait states.
    xfer(1, 1, 10'h004, 32'hA5A50F0F, 4'hF, 3'b000, -1, rd, er, lat);
    chk("ws3 write latency", 32'(lat), 32'd5);
    xfer(1, 0, 10'h004, 32'h0, 4'h0, 3'b000, -1, rd, er, lat);
    chk("ws3 read latency", 32'(lat), 32'd5);
    chk("ws3 read data", rd, 32'hA5A50F0F);

    // Error responses.
    xfer(0, 1, 10'h100, 32'hFFFFFFFF, 4'hF, 3'b000, -1, rd, er, lat);
    chk("range write err", 32'(er), 32'd1);
    xfer(0, 1, 10'h013, 32'hFFFFFFFF, 4'hF, 3'b000, -1, rd, er, lat);
    chk("misaligned write err", 32'(er), 32'd1);
    xfer(0, 0, 10'h010, 32'h0, 4'h0, 3'b000, -1, rd, er, lat);
    chk("after err data", rd, 32'hDE22BE44);
    xfer(0, 0, 10'h100, 32'h0, 4'h0, 3'b000, -1, rd, er, lat);
    chk("range read data", rd, 32'd0);
    chk("range read err", 32'(er), 32'd1);

    // Last word.
    xfer(0, 1, 10'h0FC, 32'h13579BDF, 4'hF, 3'b000, -1, rd, er, lat);
    xfer(0, 0, 10'h0FC, 32'h0, 4'h0, 3'b000, -1, rd, er, lat);
    chk("last word", rd, 32'h13579BDF);

    // Aborted write leaves memory alone.
    xfer(1, 1, 10'h004, 32'h00000000, 4'hF, 3'b000, 1, rd, er, lat);
    xfer(1, 0, 10'h004, 32'h0, 4'h0, 3'b000, -1, rd, er, lat);
    chk("abort no write", rd, 32'hA5A50F0F);

    // Protection check on the secure upper half.
    xfer(0, 1, 10'h080, 32'h0BADF00D, 4'hF, 3'b010, -1, rd, er, lat);
    chk("prot ns write err", 32'(er), PROT ? 32'd1 : 32'd0);
    xfer(0, 0, 10'h080, 32'h0, 4'h0, 3'b000, -1, rd, er, lat);
    chk("prot ns write data", rd, PROT ? 32'd0 : 32'h0BADF00D);
    xfer(0, 1, 10'h080, 32'h600DCAFE, 4'hF, 3'b000, -1, rd, er, lat);
    chk("prot s write err", 32'(er), 32'd0);
    xfer(0, 0, 10'h080, 32'h0, 4'h0, 3'b000, -1, rd, er, lat);
    chk("prot s read", rd, 32'h600DCAFE);

    // Reset during the completion cycle of a write (two wait states).
    xfer(2, 1, 10'h020, 32'h5A5A1234, 4'hF, 3'b000, -1, rd, er, lat);
    xfer(2, 0, 10'h020, 32'h0, 4'h0, 3'b000, -1, rd, er, lat);
    chk("ws2 read data", rd, 32'h5A5A1234);
    @(posedge clk); #1;
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 10'h020;
    pwdata[2] = 32'h87654321; pstrb[2] = 4'hF; pprot[2] = 3'b000;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      penable[2] = 1'b1;
      exp_rdy[2] = (k == 2);
    end
    @(negedge clk);
    chk("pre-reset pready", 32'(act_rdy[2]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid reset pready", 32'(act_rdy[2]), 32'd0);
    chk("mid reset pslverr", 32'(act_err[2]), 32'd0);
    chk("mid reset prdata", act_rd[2], 32'd0);
    set_idle(2);
    clear_model();
    @(negedge clk); #2 rst_n = 1'b1;
    xfer(2, 0, 10'h020, 32'h0, 4'h0, 3'b000, -1, rd, er, lat);
    chk("post reset target", rd, 32'd0);
    xfer(0, 0, 10'h010, 32'h0, 4'h0, 3'b000, -1, rd, er, lat);
    chk("post reset d0", rd, 32'd0);

    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb4_slave_mem.md
Name: apb4_slave_mem

Overview:
- Parametrised APB4 completer: word-addressed register-array memory with byte strobes, programmable wait states, address-range/alignment error response and an optional protection check.
- Successor to the fixed-width APB3 slave; it is the DUT behind the existing APB agent, and the pin names match that agent.
- Sits on the peripheral bus and serves as the bench's reference target.

Parameters:
- ADDR_WIDTH, 8, byte-address width of paddr_i.
- DATA_WIDTH, 32, data bus width; must be 8, 16 or 32.
- DEPTH, 64, number of words (at most 2**(ADDR_WIDTH-log2(DATA_WIDTH/8))).
- WAIT_STATES, 0, number of ACCESS cycles with pready_o low before completion (0..15).

Ports:
- pclk_i  in  1  bus clock; all state changes on the rising edge.
- presetn_i  in  1  asynchronous, active-low reset.
- psel_i  in  1  select.
- penable_i  in  1  access phase.
- pwrite_i  in  1  1 = write, 0 = read.
- paddr_i  in  ADDR_WIDTH  byte address.
- pwdata_i  in  DATA_WIDTH  write data.
- pstrb_i  in  DATA_WIDTH/8  write byte strobes.
- pprot_i  in  3  protection type; bit1 = non-secure.
- prdata_o  out  DATA_WIDTH  read data.
- pready_o  out  1  transfer complete.
- pslverr_o  out  1  error response, valid only while pready_o = 1.

Behaviour:
- Reset: one clock, pclk_i; reset presetn_i is asynchronous, active-low.
  - While presetn_i = 0: state = IDLE; prdata_o = 0, pready_o = 0, pslverr_o = 0; all memory words = 0; wait counter = 0.
  - Reset asserted mid-transfer aborts it immediately and commits no write.
- Index and error decode:
  - Word index = paddr_i >> log2(DATA_WIDTH/8).
  - err = (index >= DEPTH) OR (low address bits != 0).
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - psel_i=1, penable_i=0 -> SETUP.
  - psel_i=1, penable_i=1 (no setup phase) is ignored; stay IDLE.
- SETUP (1 cycle):
  - Capture addr, write, wdata, strb, prot and err.
  - Load wait counter = WAIT_STATES.
  - On a read with no error, capture mem[index] into the read register.
  - Next state ACCESS.
- ACCESS:
  - pready_o = (counter == 0); counter decrements each cycle while nonzero.
  - Completion edge is psel_i & penable_i & pready_o.
    - Write, no error: for every strobe bit set, update that byte from captured wdata; other bytes are unchanged.
    - Then: if psel_i=1 and penable_i=0 -> SETUP (back-to-back transfer), else -> IDLE.
  - psel_i=0 before completion -> IDLE; transfer aborted, no write.
- Output timing:
  - pready_o is combinational from state/counter.
  - prdata_o = read register when pready_o=1 and the transfer is a read without error; otherwise 0.
  - pslverr_o = captured err when pready_o=1; otherwise 0.
  - Latency: WAIT_STATES=0 gives a 2-cycle transfer; general case is 2+WAIT_STATES cycles.
- Error transfers:
  - A write with err=1 leaves memory unchanged.
  - A read with err=1 returns prdata_o = 0.
- pstrb_i on reads is ignored.
- Bus inputs that change during ACCESS are ignored; only the values captured in SETUP are used.

Optional Feature:
- Macro APB_PROT_CHECK_EN.
- Defined:
  - The upper half of the word range (index >= DEPTH/2) is secure-only.
  - A transfer with pprot_i[1]=1 to that range sets err: pslverr_o=1, no write, prdata_o=0.
- Undefined: pprot_i is ignored; the port remains present but unused.

Decomposition:
- Package apb4_pkg holds:
  - typedef enum state_t {IDLE, SETUP, ACCESS};
  - localparam STRB_WIDTH = DATA_WIDTH/8;
  - localparam WORD_LSB = $clog2(STRB_WIDTH);
  - a function decoding index and error.
- One sub-module, apb4_byte_mem: DEPTH x DATA_WIDTH array with asynchronous clear, per-byte write enables and an asynchronous read port.
- The FSM and wait counter live in the top level.

Test Plan:
- Defaults, WAIT_STATES=0: write 0xDEADBEEF to 0x10 with strb=0xF, then read 0x10 -> pready_o high on 2nd cycle of each transfer; prdata_o = 0xDEADBEEF; pslverr_o = 0.
- Partial strobe: 0x10 holds 0xDEADBEEF; write 0x11223344 with strb=0x5 -> read returns 0xDE22BE44.
- WAIT_STATES=3: read 0x04 -> pready_o low for exactly 3 ACCESS cycles, high on the 4th; transfer takes 5 cycles total.
- Errors: write to 0x100 (index 64 >= DEPTH) and to 0x13 (misaligned) -> pslverr_o=1 on the completion cycle; a follow-up read of 0x10 is unchanged.
- presetn_i dropped in the middle of a write's ACCESS (WAIT_STATES=2) -> outputs 0 immediately; after release, reading the target returns 0.
- With APB_PROT_CHECK_EN defined, write to 0x80 with pprot_i=3'b010 -> pslverr_o=1 and no write; same write with pprot_i=3'b000 succeeds and reads back.
